// File: rtl/gppcu_lmem_loader.sv
// gppcu_lmem_loader
// Host-side master for the per-thread local-memory external port. Each accepted
// command copies LEN words between a host stream and one thread's LMEM.
//
// Ports
//   iACLK, iARST                       clock, async active-high reset
//   iCMD_VALID/oCMD_READY              command handshake (ready only when idle)
//   iCMD_WR/iCMD_TID/iCMD_ADDR/iCMD_LEN  direction, thread, start word, word count
//   iWD_VALID/oWD_READY/iWD_DATA       host->LMEM write-data stream
//   oRD_VALID/iRD_READY/oRD_DATA       LMEM->host read-data stream
//   oLMEMSEL/oLMEMWREN/oLMEMADDR/oLMEMWDATA  registered LMEM port, one-hot select
//   iLMEMRDATA                         flattened read data, thread k at [k*DBW+:DBW]
//   oBUSY, oDONE, oERR                 busy, completion pulse, sticky bad-TID flag
//
// Build option: define GPPCU_LMEM_BCAST_EN to make a write to TID all-ones
// broadcast to every thread (a read to that TID then returns zeros, flagged).
//
// state  | meaning
// IDLE   | waiting for a command, oCMD_READY high
// WRITE  | accepting write beats, one LMEM write per beat
// READ   | issuing read addresses under the 2-word credit limit
// DRAIN  | all addresses issued, waiting for pipeline and FIFO to empty
// DONE   | command finished, completion pulse follows

module gppcu_lmem_loader #(
   parameter int NTHREAD = 4,
   parameter int TIDW    = 2,
   parameter int ABW     = 11,
   parameter int DBW     = 32
) (
   input  logic                   iACLK,
   input  logic                   iARST,
   input  logic                   iCMD_VALID,
   output logic                   oCMD_READY,
   input  logic                   iCMD_WR,
   input  logic [TIDW-1:0]        iCMD_TID,
   input  logic [ABW-1:0]         iCMD_ADDR,
   input  logic [ABW:0]           iCMD_LEN,
   input  logic                   iWD_VALID,
   output logic                   oWD_READY,
   input  logic [DBW-1:0]         iWD_DATA,
   output logic                   oRD_VALID,
   input  logic                   iRD_READY,
   output logic [DBW-1:0]         oRD_DATA,
   output logic [NTHREAD-1:0]     oLMEMSEL,
   output logic                   oLMEMWREN,
   output logic [ABW-1:0]         oLMEMADDR,
   output logic [DBW-1:0]         oLMEMWDATA,
   input  logic [NTHREAD*DBW-1:0] iLMEMRDATA,
   output logic                   oBUSY,
   output logic                   oDONE,
   output logic                   oERR
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]         state_q, state_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [TIDW-1:0]    tid_q, tid_d;
   logic               rd_ok_q, rd_ok_d;
   logic [NTHREAD-1:0] sel_mask_q, sel_mask_d;
   logic [ABW-1:0]     addr_q, addr_d;
   logic [ABW:0]       rem_q, rem_d;
   logic [NTHREAD-1:0] lmem_sel_q, lmem_sel_d;
   logic               lmem_wren_q, lmem_wren_d;
   logic [ABW-1:0]     lmem_addr_q, lmem_addr_d;
   logic [DBW-1:0]     lmem_wdata_q, lmem_wdata_d;
   // rd_v1: read address on the port this cycle; rd_v2: its data arrives this cycle
   logic               rd_v1_q, rd_v1_d;
   logic               rd_v2_q, rd_v2_d;
   logic [DBW-1:0]     fifo_mem_q [0:1];
   logic [DBW-1:0]     fifo_mem_d [0:1];
   logic               fifo_wp_q, fifo_wp_d;
   logic               fifo_rp_q, fifo_rp_d;
   logic [1:0]         fifo_cnt_q, fifo_cnt_d;

   logic               cmd_fire, wd_ready, wd_fire, rd_valid, push, pop, issue;
   logic               tid_ok, bcast_id;
   logic [NTHREAD-1:0] tid_onehot;
   logic [DBW-1:0]     rd_mux;
   logic [2:0]         occ;

   assign cmd_fire = iCMD_VALID & cmd_ready_q;
   assign wd_ready = (state_q == S_WRITE) && (rem_q != '0);
   assign wd_fire  = iWD_VALID & wd_ready;
   assign rd_valid = (fifo_cnt_q != 2'd0);
   assign pop      = rd_valid & iRD_READY;
   assign push     = rd_v2_q;
   assign tid_ok   = (32'(iCMD_TID) < 32'(NTHREAD));

`ifdef GPPCU_LMEM_BCAST_EN
   assign bcast_id = (iCMD_TID == {TIDW{1'b1}});
`else
   assign bcast_id = 1'b0;
`endif

   // Words buffered plus in flight as they will stand when the address decided
   // now reaches the port; issuing only below 2 keeps the FIFO from overflowing.
   assign occ   = 3'(fifo_cnt_q) + 3'(rd_v1_q) + 3'(rd_v2_q) - 3'(pop);
   assign issue = (state_q == S_READ) && (rem_q != '0) && (occ < 3'd2);

   always_comb begin
      tid_onehot = '0;
      for (int k = 0; k < NTHREAD; k++) tid_onehot[k] = (iCMD_TID == TIDW'(k));
   end

   always_comb begin
      rd_mux = '0;
      for (int k = 0; k < NTHREAD; k++)
         if (rd_ok_q && (tid_q == TIDW'(k))) rd_mux = iLMEMRDATA[k*DBW +: DBW];
   end

   always_comb begin
      state_d      = state_q;
      err_d        = err_q;
      tid_d        = tid_q;
      rd_ok_d      = rd_ok_q;
      sel_mask_d   = sel_mask_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      lmem_sel_d   = '0;
      lmem_wren_d  = 1'b0;
      lmem_addr_d  = lmem_addr_q;
      lmem_wdata_d = lmem_wdata_q;
      rd_v1_d      = 1'b0;
      rd_v2_d      = rd_v1_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               tid_d      = iCMD_TID;
               addr_d     = iCMD_ADDR;
               rem_d      = iCMD_LEN;
               err_d      = bcast_id ? ~iCMD_WR : ~tid_ok;
               rd_ok_d    = tid_ok & ~bcast_id;
               sel_mask_d = bcast_id ? (iCMD_WR ? '1 : '0) : (tid_ok ? tid_onehot : '0);
               if (iCMD_LEN == '0) state_d = S_DONE;
               else if (iCMD_WR)   state_d = S_WRITE;
               else                state_d = S_READ;
            end
         end
         S_WRITE: begin
            if (wd_fire) begin
               lmem_sel_d   = sel_mask_q;
               lmem_wren_d  = 1'b1;
               lmem_addr_d  = addr_q;
               lmem_wdata_d = iWD_DATA;
               addr_d       = addr_q + 1'b1;
               rem_d        = rem_q - 1'b1;
               if (rem_q == (ABW+1)'(1)) state_d = S_DONE;
            end
         end
         S_READ: begin
            if (issue) begin
               lmem_sel_d  = sel_mask_q;
               lmem_addr_d = addr_q;
               rd_v1_d     = 1'b1;
               addr_d      = addr_q + 1'b1;
               rem_d       = rem_q - 1'b1;
               if (rem_q == (ABW+1)'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((fifo_cnt_q == 2'd0) && !rd_v1_q && !rd_v2_q) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      fifo_mem_d = fifo_mem_q;
      fifo_wp_d  = fifo_wp_q;
      fifo_rp_d  = fifo_rp_q;
      if (push) begin
         fifo_mem_d[fifo_wp_q] = rd_mux;
         fifo_wp_d             = ~fifo_wp_q;
      end
      if (pop) fifo_rp_d = ~fifo_rp_q;
      fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);
   end

   assign cmd_ready_d = (state_d == S_IDLE);
   assign done_d      = (state_q == S_DONE);

   always_ff @(posedge iACLK or posedge iARST) begin
      if (iARST) begin
         state_q      <= S_IDLE;
         cmd_ready_q  <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         tid_q        <= '0;
         rd_ok_q      <= 1'b0;
         sel_mask_q   <= '0;
         addr_q       <= '0;
         rem_q        <= '0;
         lmem_sel_q   <= '0;
         lmem_wren_q  <= 1'b0;
         lmem_addr_q  <= '0;
         lmem_wdata_q <= '0;
         rd_v1_q      <= 1'b0;
         rd_v2_q      <= 1'b0;
         fifo_mem_q   <= '{default: '0};
         fifo_wp_q    <= 1'b0;
         fifo_rp_q    <= 1'b0;
         fifo_cnt_q   <= 2'd0;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         done_q       <= done_d;
         err_q        <= err_d;
         tid_q        <= tid_d;
         rd_ok_q      <= rd_ok_d;
         sel_mask_q   <= sel_mask_d;
         addr_q       <= addr_d;
         rem_q        <= rem_d;
         lmem_sel_q   <= lmem_sel_d;
         lmem_wren_q  <= lmem_wren_d;
         lmem_addr_q  <= lmem_addr_d;
         lmem_wdata_q <= lmem_wdata_d;
         rd_v1_q      <= rd_v1_d;
         rd_v2_q      <= rd_v2_d;
         fifo_mem_q   <= fifo_mem_d;
         fifo_wp_q    <= fifo_wp_d;
         fifo_rp_q    <= fifo_rp_d;
         fifo_cnt_q   <= fifo_cnt_d;
      end
   end

   assign oCMD_READY = cmd_ready_q;
   assign oWD_READY  = wd_ready;
   assign oRD_VALID  = rd_valid;
   assign oRD_DATA   = fifo_mem_q[fifo_rp_q];
   assign oLMEMSEL   = lmem_sel_q;
   assign oLMEMWREN  = lmem_wren_q;
   assign oLMEMADDR  = lmem_addr_q;
   assign oLMEMWDATA = lmem_wdata_q;
   assign oBUSY      = (state_q != S_IDLE);
   assign oDONE      = done_q;
   assign oERR       = err_q;

endmodule

// File: tb/tb_gppcu_lmem_loader.sv
module tb_gppcu_lmem_loader;
   localparam int NT = 3;
   localparam int TW = 2;
   localparam int AW = 11;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cmd_valid = 1'b0, cmd_wr = 1'b0;
   logic [TW-1:0] cmd_tid = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [AW:0]   cmd_len = '0;
   logic wd_valid = 1'b0, rd_ready = 1'b0;
   logic [DW-1:0] wd_data = '0;
   logic cmd_ready, wd_ready, rd_valid, lm_wren, busy, done, err;
   logic [DW-1:0] rd_data, lm_wdata;
   logic [NT-1:0] lm_sel;
   logic [AW-1:0] lm_addr;
   logic [NT*DW-1:0] lm_rdata;

   gppcu_lmem_loader #(.NTHREAD(NT), .TIDW(TW), .ABW(AW), .DBW(DW)) dut (
      .iACLK(clk), .iARST(rst),
      .iCMD_VALID(cmd_valid), .oCMD_READY(cmd_ready), .iCMD_WR(cmd_wr),
      .iCMD_TID(cmd_tid), .iCMD_ADDR(cmd_addr), .iCMD_LEN(cmd_len),
      .iWD_VALID(wd_valid), .oWD_READY(wd_ready), .iWD_DATA(wd_data),
      .oRD_VALID(rd_valid), .iRD_READY(rd_ready), .oRD_DATA(rd_data),
      .oLMEMSEL(lm_sel), .oLMEMWREN(lm_wren), .oLMEMADDR(lm_addr),
      .oLMEMWDATA(lm_wdata), .iLMEMRDATA(lm_rdata),
      .oBUSY(busy), .oDONE(done), .oERR(err));

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(int k, int a);
      return 32'hC000_0000 | (32'(k) << 16) | 32'(a);
   endfunction

   // Thread LMEM models: synchronous RAMs with one-cycle read latency.
   logic [DW-1:0] lmem [NT][2048];
   bit            wrtn [NT][2048];
   always @(posedge clk) begin
      for (int k = 0; k < NT; k++)
         if (lm_sel[k]) begin
            if (lm_wren) begin
               lmem[k][lm_addr] <= lm_wdata;
               wrtn[k][lm_addr] <= 1'b1;
            end else
               lm_rdata[k*DW +: DW] <= wrtn[k][lm_addr] ? lmem[k][lm_addr] : pat(k, int'(lm_addr));
         end
   end

   // Bench-side reference of what each thread's memory should hold.
   logic [DW-1:0] ref_mem [NT][2048];
   bit            ref_wr  [NT][2048];
   logic [63:0]   exp_wr [$];
   logic [31:0]   exp_rd [$];

   int n_cmp = 0, n_err = 0;
   int cyc = 0, acc_cyc = 0, done_cyc = 0, first_wr = 0, last_wr = 0;
   int wr_cnt = 0, sel_cnt = 0, issued = 0, popped = 0;
   bit acc = 0, wd_fired = 0, done_seen = 0, chk_occ = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      acc = cmd_valid && cmd_ready;
      if (acc) acc_cyc = cyc;
      wd_fired = wd_valid && wd_ready;
      if (lm_wren) begin
         if (wr_cnt == 0) first_wr = cyc;
         last_wr = cyc;
         wr_cnt++;
         if (exp_wr.size() == 0) check("wr_unexpected", 64'(lm_wren), 64'd0);
         else check("wr_beat", 64'({lm_sel, lm_addr, lm_wdata}), exp_wr.pop_front());
      end
      if (|lm_sel) sel_cnt++;
      if (|lm_sel && !lm_wren) issued++;
      if (chk_occ) check("occupancy_le2", 64'((issued - popped) <= 2), 64'd1);
      if (rd_valid && rd_ready) begin
         popped++;
         if (exp_rd.size() == 0) check("rd_unexpected", 64'(rd_valid), 64'd0);
         else check("rd_word", 64'(rd_data), 64'(exp_rd.pop_front()));
      end
      if (done) begin
         done_seen = 1;
         done_cyc  = cyc;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NT-1:0] wr_sel(int tid);
`ifdef GPPCU_LMEM_BCAST_EN
      if (tid == (1 << TW) - 1) return '1;
`endif
      return (tid < NT) ? NT'(1 << tid) : '0;
   endfunction

   function automatic bit rd_valid_tid(int tid);
`ifdef GPPCU_LMEM_BCAST_EN
      if (tid == (1 << TW) - 1) return 0;
`endif
      return tid < NT;
   endfunction

   task automatic do_cmd(input bit wr, input int tid, input int addr, input int len);
      done_seen = 0;
      cmd_wr = wr; cmd_tid = TW'(tid); cmd_addr = AW'(addr); cmd_len = (AW+1)'(len);
      cmd_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         tick();
         if (acc) break;
      end
      cmd_valid = 1'b0;
      check("cmd_accept", 64'(acc), 64'd1);
   endtask

   task automatic run_done(input int mode);
      int n = 0;
      while (!done_seen && n < 300) begin
         rd_ready = (mode == 0) ? 1'b1 : (n % 3 == 0);
         tick();
         n++;
      end
      check("done_seen", 64'(done_seen), 64'd1);
   endtask

   task automatic do_write(input int tid, input int addr, input int len, input logic [31:0] base);
      int i = 0, n = 0;
      logic [NT-1:0] s = wr_sel(tid);
      for (int j = 0; j < len; j++) begin
         logic [AW-1:0] a = AW'(addr + j);
         exp_wr.push_back(64'({s, a, base + 32'(j)}));
         for (int k = 0; k < NT; k++)
            if (s[k]) begin ref_mem[k][a] = base + 32'(j); ref_wr[k][a] = 1; end
      end
      wr_cnt = 0;
      do_cmd(1'b1, tid, addr, len);
      while (i < len && n < 100) begin
         wd_valid = 1'b1;
         wd_data  = base + 32'(i);
         tick();
         if (wd_fired) i++;
         n++;
      end
      wd_valid = 1'b0;
      run_done(0);
      check("wr_all_issued", 64'(exp_wr.size()), 64'd0);
   endtask

   task automatic do_read(input int tid, input int addr, input int len, input int mode);
      for (int j = 0; j < len; j++) begin
         logic [AW-1:0] a = AW'(addr + j);
         if (!rd_valid_tid(tid)) exp_rd.push_back(32'd0);
         else exp_rd.push_back(ref_wr[tid][a] ? ref_mem[tid][a] : pat(tid, int'(a)));
      end
      issued = 0; popped = 0;
      rd_ready = (mode == 0);
      do_cmd(1'b0, tid, addr, len);
      run_done(mode);
      check("rd_all_delivered", 64'(exp_rd.size()), 64'd0);
      check("rd_pop_count", 64'(popped), 64'(len));
      rd_ready = 1'b0;
   endtask

   initial begin
      // reset state
      tick();
      check("reset_outs", 64'({cmd_ready, busy, done, err, wd_ready, rd_valid, lm_sel, lm_wren, lm_addr}), 64'd0);
      rst = 1'b0;
      tick();
      check("ready_after_reset", 64'(cmd_ready), 64'd1);

      // write tid1, four consecutive beats, done one cycle after the last
      do_write(1, 'h010, 4, 32'hA0);
      check("wr_beats", 64'(wr_cnt), 64'd4);
      check("wr_consecutive", 64'(last_wr - first_wr), 64'd3);
      check("wr_done_lat", 64'(done_cyc - last_wr), 64'd1);
      check("wr_err", 64'(err), 64'd0);

      // read back with ready held high
      do_read(1, 'h010, 4, 0);

      // read 6 words with a stalling consumer, credit limit checked each cycle
      chk_occ = 1;
      do_read(2, 'h100, 6, 1);
      chk_occ = 0;

      // address wrap on write and read
      do_write(0, 'h7FE, 3, 32'h0B00);
      do_read(0, 'h7FE, 3, 0);

      // zero-length command
      sel_cnt = 0;
      do_cmd(1'b1, 0, 'h020, 0);
      run_done(0);
      check("len0_done_lat", 64'(done_cyc - acc_cyc), 64'd2);
      check("len0_no_sel", 64'(sel_cnt), 64'd0);

      // invalid thread id
      sel_cnt = 0;
      do_cmd(1'b0, 3, 'h010, 0);
      run_done(0);
      check("bad_tid_err", 64'(err), 64'd1);
      do_read(3, 'h010, 2, 0);
      check("bad_tid_no_sel", 64'(sel_cnt), 64'd0);
      check("bad_tid_err_sticky", 64'(err), 64'd1);
      do_read(0, 'h300, 1, 0);
      check("err_cleared", 64'(err), 64'd0);

      // reset in the middle of a read
      rd_ready = 1'b0;
      for (int j = 0; j < 4; j++) exp_rd.push_back(32'hA0 + 32'(j));
      do_cmd(1'b0, 1, 'h010, 4);
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      check("midrst_outs", 64'({rd_valid, busy, lm_sel, lm_wren, cmd_ready, done, wd_ready, err}), 64'd0);
      exp_rd.delete();
      tick();
      rst = 1'b0;
      tick();
      do_read(1, 'h012, 2, 0);

`ifdef GPPCU_LMEM_BCAST_EN
      do_write(3, 'h055, 1, 32'hBB);
      check("bcast_err", 64'(err), 64'd0);
      tick();
      for (int k = 0; k < NT; k++) check("bcast_mem", 64'(lmem[k][11'h055]), 64'hBB);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
